// File: rtl/tsv_cascade_counter_bank.sv
// Bank of NCH chained WIDTH-bit up-counters with per-channel clear, single-channel load and a ripple carry
// intended to cross tiers via TSV pairs. Optional macro CARRY_OUT_REG_EN registers carry_OUT.
module tsv_cascade_counter_bank #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned NCH   = 4,
  parameter int unsigned CHW   = 2
) (
  input  logic                 clk1_IN,
  input  logic                 rst_n_IN,
  input  logic                 en_IN,
  input  logic                 carry_IN,
  input  logic [NCH-1:0]       clr_IN,
  input  logic                 load_IN,
  input  logic [CHW-1:0]       load_ch_IN,
  input  logic [WIDTH-1:0]     load_val_IN,
  output logic [NCH*WIDTH-1:0] cnt_OUT,
  output logic [NCH-1:0]       tc_OUT,
  output logic                 carry_OUT,
  output logic                 all_ones_n_OUT
);

  logic [NCH-1:0][WIDTH-1:0] cnt_q;
  logic [NCH-1:0][WIDTH-1:0] cnt_d;
  logic [NCH-1:0]            tc_c;
  logic [NCH-1:0]            adv_c;
  logic                      carry_c;

  // Advance chain is built from pre-edge register values, so same-edge clear/load never break it.
  always_comb begin
    tc_c  = '0;
    adv_c = '0;
    cnt_d = cnt_q;
    for (int k = 0; k < int'(NCH); k++) begin
      tc_c[k] = &cnt_q[k];
    end
    adv_c[0] = en_IN & carry_IN;
    for (int k = 1; k < int'(NCH); k++) begin
      adv_c[k] = adv_c[k-1] & tc_c[k-1];
    end
    for (int k = 0; k < int'(NCH); k++) begin
      if (clr_IN[k]) begin
        cnt_d[k] = '0;
      end else if (load_IN && (load_ch_IN == CHW'(k))) begin
        cnt_d[k] = load_val_IN;
      end else if (adv_c[k]) begin
        cnt_d[k] = cnt_q[k] + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk1_IN or negedge rst_n_IN) begin
    if (!rst_n_IN) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign carry_c = adv_c[NCH-1] & tc_c[NCH-1];

`ifdef CARRY_OUT_REG_EN
  // Registered carry cuts the inter-tier timing path at the cost of one cycle of lag.
  logic carry_q;

  always_ff @(posedge clk1_IN or negedge rst_n_IN) begin
    if (!rst_n_IN) begin
      carry_q <= 1'b0;
    end else begin
      carry_q <= carry_c;
    end
  end

  assign carry_OUT = carry_q;
`else
  assign carry_OUT = carry_c;
`endif

  assign cnt_OUT        = cnt_q;
  assign tc_OUT         = tc_c;
  assign all_ones_n_OUT = ~(&tc_c);

endmodule
